// File: rtl/sram_1rw1r_arbiter_if.sv
// Requester and macro-pin bundle for the 1RW/1R SRAM arbiter.
// slave = arbiter side, master = requesters plus macro side.
interface sram_1rw1r_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) ();
    logic                  a_req;
    logic                  a_we;
    logic [NUM_WMASKS-1:0] a_wmask;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [NUM_WMASKS-1:0] b_wmask;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  c_req;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic [DATA_WIDTH-1:0] c_rdata;

    logic                  sram_csb0;
    logic                  sram_web0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0;
    logic                  sram_csb1;
    logic [ADDR_WIDTH-1:0] sram_addr1;
    logic [DATA_WIDTH-1:0] sram_dout1;

    modport slave (
        input  a_req, a_we, a_wmask, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_wmask, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        input  c_req, c_addr,
        output c_gnt, c_rvalid, c_rdata,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_dout0,
        output sram_csb1, sram_addr1,
        input  sram_dout1
    );

    modport master (
        output a_req, a_we, a_wmask, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_wmask, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        output c_req, c_addr,
        input  c_gnt, c_rvalid, c_rdata,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_dout0,
        input  sram_csb1, sram_addr1,
        output sram_dout1
    );
endinterface

// File: rtl/sram_1rw1r_arbiter.sv
// Round-robin A/B arbiter on SRAM port 0, C on read-only port 1,
// with write/read collision blocking and two-stage read return routing.
module sram_1rw1r_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input logic                 clk0,
    input logic                 rst0,
    sram_1rw1r_arbiter_if.slave bus
);
    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_e;

    sel_e                  last;
    logic                  a_win;
    logic                  b_win;
    logic                  p0_gnt;
    logic                  p0_we;
    logic [NUM_WMASKS-1:0] p0_wmask;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  c_win;

    logic                  s1_p0_valid;
    logic                  s1_p0_id;
    logic                  s1_p1_valid;

    logic                  a_rvalid;
    logic                  b_rvalid;
    logic                  c_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic [DATA_WIDTH-1:0] c_rdata;

    // Grants are forced low while reset is held.
    always_comb begin
        a_win    = 1'b0;
        b_win    = 1'b0;
        p0_gnt   = 1'b0;
        p0_we    = 1'b0;
        p0_wmask = '0;
        p0_addr  = '0;
        p0_wdata = '0;
        c_win    = 1'b0;
        if (!rst0) begin
            a_win  = bus.a_req && (!bus.b_req || last == SEL_B);
            b_win  = bus.b_req && !a_win;
            p0_gnt = a_win || b_win;
            unique case (1'b1)
                a_win: begin
                    p0_we    = bus.a_we;
                    p0_wmask = bus.a_wmask;
                    p0_addr  = bus.a_addr;
                    p0_wdata = bus.a_wdata;
                end
                b_win: begin
                    p0_we    = bus.b_we;
                    p0_wmask = bus.b_wmask;
                    p0_addr  = bus.b_addr;
                    p0_wdata = bus.b_wdata;
                end
                default: ;
            endcase
            c_win = bus.c_req &&
                    !(p0_gnt && p0_we && p0_addr == bus.c_addr);
        end
    end

    assign bus.a_gnt       = a_win;
    assign bus.b_gnt       = b_win;
    assign bus.c_gnt       = c_win;
    assign bus.sram_csb0   = !p0_gnt;
    assign bus.sram_web0   = !(p0_gnt && p0_we);
    assign bus.sram_wmask0 = p0_wmask;
    assign bus.sram_addr0  = p0_addr;
    assign bus.sram_din0   = p0_wdata;
    assign bus.sram_csb1   = !c_win;
    assign bus.sram_addr1  = c_win ? bus.c_addr : '0;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            last <= SEL_B;
        end else if (a_win) begin
            last <= SEL_A;
        end else if (b_win) begin
            last <= SEL_B;
        end
    end

    // Stage 1: remember which reads are in flight and who owns them.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            s1_p0_valid <= 1'b0;
            s1_p0_id    <= 1'b0;
            s1_p1_valid <= 1'b0;
        end else begin
            s1_p0_valid <= p0_gnt && !p0_we;
            s1_p0_id    <= b_win;
            s1_p1_valid <= c_win;
        end
    end

    // Stage 2: capture macro dout into the owner's register only.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            c_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            c_rdata  <= '0;
        end else begin
            a_rvalid <= s1_p0_valid && !s1_p0_id;
            b_rvalid <= s1_p0_valid && s1_p0_id;
            c_rvalid <= s1_p1_valid;
            if (s1_p0_valid && !s1_p0_id) begin
                a_rdata <= bus.sram_dout0;
            end
            if (s1_p0_valid && s1_p0_id) begin
                b_rdata <= bus.sram_dout0;
            end
            if (s1_p1_valid) begin
                c_rdata <= bus.sram_dout1;
            end
        end
    end

    assign bus.a_rvalid = a_rvalid;
    assign bus.b_rvalid = b_rvalid;
    assign bus.c_rvalid = c_rvalid;
    assign bus.a_rdata  = a_rdata;
    assign bus.b_rdata  = b_rdata;
    assign bus.c_rdata  = c_rdata;
endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// Directed bench for sram_1rw1r_arbiter with a behavioural 1RW/1R macro.
// Macro dout changes on the falling edge after the addressing rising edge.
module tb_sram_1rw1r_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sram_1rw1r_arbiter_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)
    ) bus ();

    sram_1rw1r_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)
    ) dut (
        .clk0(clk),
        .rst0(rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:2047];
    logic [AW-1:0] rd0_addr;
    logic [AW-1:0] rd1_addr;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 + i;
        rd0_addr = '0;
        rd1_addr = '0;
    end

    always @(posedge clk) begin
        if (!bus.sram_csb0) begin
            if (!bus.sram_web0) begin
                for (int l = 0; l < MW; l++)
                    if (bus.sram_wmask0[l])
                        mem[bus.sram_addr0][l*8 +: 8] <= bus.sram_din0[l*8 +: 8];
            end else begin
                rd0_addr <= bus.sram_addr0;
            end
        end
        if (!bus.sram_csb1) rd1_addr <= bus.sram_addr1;
    end

    always @(negedge clk) begin
        bus.sram_dout0 <= mem[rd0_addr];
        bus.sram_dout1 <= mem[rd1_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_req = 0; bus.a_we = 0; bus.a_wmask = 0;
        bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_wmask = 0;
        bus.b_addr = 0; bus.b_wdata = 0;
        bus.c_req = 0; bus.c_addr = 0;
    endtask

    logic [31:0] exp_c [0:7];

    initial begin
        checks = 0;
        errors = 0;
        exp_c = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                  32'hC0DE0004, 32'hDEADBEEF, 32'hC0DE0006, 32'hC0DE0007};
        rst = 1;
        idle();
        bus.a_req = 1; bus.a_addr = 5;
        bus.c_req = 1; bus.c_addr = 3;
        #2;
        chk("rst_a_gnt", bus.a_gnt, 0);
        chk("rst_c_gnt", bus.c_gnt, 0);
        chk("rst_csb0", bus.sram_csb0, 1);
        chk("rst_csb1", bus.sram_csb1, 1);
        chk("rst_web0", bus.sram_web0, 1);
        chk("rst_addr0", bus.sram_addr0, 0);
        step();
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_c_rdata", bus.c_rdata, 0);
        step();
        rst = 0;
        idle();
        step();

        // single write then read on A
        bus.a_req = 1; bus.a_we = 1; bus.a_wmask = 4'hF;
        bus.a_addr = 5; bus.a_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_a_gnt", bus.a_gnt, 1);
        chk("wr_csb0", bus.sram_csb0, 0);
        chk("wr_web0", bus.sram_web0, 0);
        chk("wr_addr0", bus.sram_addr0, 5);
        step();
        bus.a_we = 0;
        #1;
        chk("rd_a_gnt", bus.a_gnt, 1);
        chk("rd_web0", bus.sram_web0, 1);
        step();
        idle();
        #1;
        chk("rd_a_rvalid_n2", bus.a_rvalid, 0);
        chk("idle_csb0", bus.sram_csb0, 1);
        step();
        chk("rd_a_rvalid", bus.a_rvalid, 1);
        chk("rd_a_rdata", bus.a_rdata, 32'hDEADBEEF);
        chk("rd_b_rvalid", bus.b_rvalid, 0);
        step();
        chk("rd_a_pulse", bus.a_rvalid, 0);
        chk("rd_a_hold", bus.a_rdata, 32'hDEADBEEF);

        // byte mask on B at the top address
        bus.b_req = 1; bus.b_we = 1; bus.b_wmask = 4'hF;
        bus.b_addr = 11'd2047; bus.b_wdata = 32'h11223344;
        #1;
        chk("bm_gnt0", bus.b_gnt, 1);
        step();
        bus.b_wmask = 4'h5; bus.b_wdata = 32'hAABBCCDD;
        #1;
        chk("bm_wmask0", bus.sram_wmask0, 4'h5);
        step();
        bus.b_we = 0;
        #1;
        chk("bm_rd_gnt", bus.b_gnt, 1);
        chk("bm_addr0", bus.sram_addr0, 11'd2047);
        step();
        idle();
        step();
        chk("bm_rvalid", bus.b_rvalid, 1);
        chk("bm_rdata", bus.b_rdata, 32'h11BB33DD);
        chk("bm_a_rvalid", bus.a_rvalid, 0);
        chk("bm_a_hold", bus.a_rdata, 32'hDEADBEEF);
        step();

        // round robin, A wins first since B was granted last
        for (int k = 0; k < 6; k++) begin
            bus.a_req = (k < 4); bus.a_addr = 10;
            bus.b_req = (k < 4); bus.b_addr = 11;
            #1;
            if (k < 4) begin
                chk($sformatf("rr_a_gnt%0d", k), bus.a_gnt, (k % 2 == 0));
                chk($sformatf("rr_b_gnt%0d", k), bus.b_gnt, (k % 2 == 1));
            end
            if (k >= 2) begin
                chk($sformatf("rr_a_rv%0d", k), bus.a_rvalid, (k % 2 == 0));
                chk($sformatf("rr_b_rv%0d", k), bus.b_rvalid, (k % 2 == 1));
                if (k % 2 == 0)
                    chk($sformatf("rr_a_rd%0d", k), bus.a_rdata, 32'hC0DE000A);
                else
                    chk($sformatf("rr_b_rd%0d", k), bus.b_rdata, 32'hC0DE000B);
            end
            step();
        end
        idle();
        step();

        // same-address collision: write wins, C retries
        bus.a_req = 1; bus.a_we = 1; bus.a_wmask = 4'hF;
        bus.a_addr = 100; bus.a_wdata = 32'h12345678;
        bus.c_req = 1; bus.c_addr = 100;
        #1;
        chk("col_a_gnt", bus.a_gnt, 1);
        chk("col_c_gnt", bus.c_gnt, 0);
        chk("col_csb1", bus.sram_csb1, 1);
        step();
        bus.a_req = 0;
        #1;
        chk("col_c_retry", bus.c_gnt, 1);
        chk("col_addr1", bus.sram_addr1, 100);
        step();
        bus.c_req = 0;
        step();
        chk("col_c_rvalid", bus.c_rvalid, 1);
        chk("col_c_rdata", bus.c_rdata, 32'h12345678);

        // differing addresses proceed together
        bus.a_req = 1; bus.a_we = 1; bus.a_wmask = 4'hF;
        bus.a_addr = 100; bus.a_wdata = 32'h9ABCDEF0;
        bus.c_req = 1; bus.c_addr = 101;
        #1;
        chk("nc_a_gnt", bus.a_gnt, 1);
        chk("nc_c_gnt", bus.c_gnt, 1);
        step();
        idle();
        step();
        chk("nc_c_rvalid", bus.c_rvalid, 1);
        chk("nc_c_rdata", bus.c_rdata, 32'hC0DE0065);
        step();

        // back-to-back port 1 reads
        for (int k = 0; k < 10; k++) begin
            bus.c_req = (k < 8);
            bus.c_addr = (k < 8) ? AW'(k) : '0;
            #1;
            if (k < 8) chk($sformatf("bb_gnt%0d", k), bus.c_gnt, 1);
            if (k >= 2) begin
                chk($sformatf("bb_rv%0d", k), bus.c_rvalid, 1);
                chk($sformatf("bb_rd%0d", k), bus.c_rdata, exp_c[k-2]);
            end
            step();
        end
        idle();
        #1;
        chk("bb_end", bus.c_rvalid, 0);

        // reset one cycle after an A read grant
        bus.a_req = 1; bus.a_addr = 10;
        #1;
        chk("mr_a_gnt", bus.a_gnt, 1);
        step();
        idle();
        rst = 1;
        #1;
        chk("mr_a_rdata", bus.a_rdata, 0);
        chk("mr_b_rdata", bus.b_rdata, 0);
        chk("mr_c_rdata", bus.c_rdata, 0);
        chk("mr_csb0", bus.sram_csb0, 1);
        step();
        chk("mr_rvalid1", bus.a_rvalid, 0);
        rst = 0;
        step();
        chk("mr_rvalid2", bus.a_rvalid, 0);
        chk("mr_rdata2", bus.a_rdata, 0);
        bus.a_req = 1; bus.a_addr = 10;
        bus.b_req = 1; bus.b_addr = 11;
        #1;
        chk("mr_rr_a", bus.a_gnt, 1);
        chk("mr_rr_b", bus.b_gnt, 0);
        step();
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
